// File: rtl/branch_hist_table.sv
// branch_hist_table: 2-bit saturating-counter pattern history table with two
// training ports, a flush and saturating accuracy statistics.
`default_nettype none

module branch_hist_table #(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] INIT_CNT = 2'b01,
    parameter int         STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  phb_addr,
    output logic              phb_ena,
    input  logic              upd1_ena,
    input  logic [IDX_W-1:0]  upd1_addr,
    input  logic              upd1_taken,
    input  logic              upd1_mispred,
    input  logic              upd2_ena,
    input  logic [IDX_W-1:0]  upd2_addr,
    input  logic              upd2_taken,
    input  logic              upd2_mispred,
    input  logic              flush_ena,
    output logic [STAT_W-1:0] stat_resolved,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]        cnt     [DEPTH];
    logic [1:0]        cnt_nxt [DEPTH];
    logic [1:0]        res_inc;
    logic [1:0]        mis_inc;
    logic [STAT_W-1:0] resolved_nxt;
    logic [STAT_W-1:0] mispred_nxt;

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'b01;
        else       return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                 input logic [1:0]        b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + (STAT_W+1)'(b);
        return s[STAT_W] ? {STAT_W{1'b1}} : s[STAT_W-1:0];
    endfunction

    // Lookup reads the registered table only: no bypass of in-flight updates.
    assign phb_ena = cnt[phb_addr][1];

    // Port 2 is younger, so on an index collision it steps port 1's result.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (upd1_ena && (upd1_addr == IDX_W'(i)))
                cnt_nxt[i] = sat_step(cnt_nxt[i], upd1_taken);
            if (upd2_ena && (upd2_addr == IDX_W'(i)))
                cnt_nxt[i] = sat_step(cnt_nxt[i], upd2_taken);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) cnt[i] <= INIT_CNT;
        end else if (flush_ena) begin
            for (int i = 0; i < DEPTH; i++) cnt[i] <= INIT_CNT;
        end else begin
            for (int i = 0; i < DEPTH; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    always_comb begin
        res_inc      = {1'b0, upd1_ena} + {1'b0, upd2_ena};
        mis_inc      = {1'b0, upd1_ena & upd1_mispred} + {1'b0, upd2_ena & upd2_mispred};
        resolved_nxt = sat_add(stat_resolved, res_inc);
        mispred_nxt  = sat_add(stat_mispred, mis_inc);
    end

    // Statistics keep counting through a flush; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            stat_resolved <= resolved_nxt;
            stat_mispred  <= mispred_nxt;
        end
    end

endmodule

`default_nettype wire
